// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the sync generator / player inputs and the pong game controller.
// frame_tick is the only strobe: a single-cycle pulse with no back-pressure, all other outputs are levels.
interface pong_game_ctrl_if;
    logic [9:0] hsp;
    logic [9:0] vsp;
    logic       btn_lu;
    logic       btn_ld;
    logic       btn_ru;
    logic       btn_rd;
    logic       start;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [9:0] pad_l_y;
    logic [9:0] pad_r_y;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [2:0] state;
    logic       frame_tick;

    modport master (
        output hsp, vsp, btn_lu, btn_ld, btn_ru, btn_rd, start,
        input  ball_x, ball_y, pad_l_y, pad_r_y, score_l, score_r, state, frame_tick
    );

    modport slave (
        input  hsp, vsp, btn_lu, btn_ld, btn_ru, btn_rd, start,
        output ball_x, ball_y, pad_l_y, pad_r_y, score_l, score_r, state, frame_tick
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game controller: ball physics, paddles, scoring and game FSM, updated once per frame
// at the start of vertical blank so positions never change while the picture is drawn.
module pong_game_ctrl #(
    parameter int BALL_SPD     = 2,
    parameter int PAD_SPD      = 4,
    parameter int PAD_H        = 64,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 7
) (
    input  logic              clk,
    input  logic              rst,
    pong_game_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [9:0] BALL_X0 = 10'd316;
    localparam logic [9:0] BALL_Y0 = 10'd236;
    localparam logic [9:0] PAD_Y0  = 10'd208;
    localparam logic [3:0] C_WIN   = 4'(WIN_SCORE);

    localparam logic signed [11:0] C_ZERO   = 12'sd0;
    localparam logic signed [11:0] C_EIGHT  = 12'sd8;
    localparam logic signed [11:0] C_BSPD   = 12'(BALL_SPD);
    localparam logic signed [11:0] C_PSPD   = 12'(PAD_SPD);
    localparam logic signed [11:0] C_PADH   = 12'(PAD_H);
    localparam logic signed [11:0] C_PADMAX = 12'(480 - PAD_H);
    localparam logic signed [11:0] C_YMAX   = 12'sd472;
    localparam logic signed [11:0] C_LFACE  = 12'sd24;
    localparam logic signed [11:0] C_RFACE  = 12'sd616;
    localparam logic signed [11:0] C_RSTOP  = 12'sd608;
    localparam logic signed [11:0] C_XMAX   = 12'sd632;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_frame_tick;
    logic             r_vb_d;
    logic [9:0]       r_ball_x;
    logic [9:0]       r_ball_y;
    logic [9:0]       r_pad_l;
    logic [9:0]       r_pad_r;
    logic [3:0]       r_score_l;
    logic [3:0]       r_score_r;
    logic             r_dx;
    logic             r_dy;
    logic             r_srv_dir;
    logic             r_point_r;
    logic [CNT_W-1:0] r_cnt;

    logic             w_vb;
    logic signed [11:0] w_bx, w_by, w_pl, w_pr, w_nx, w_ny;
    logic signed [11:0] w_play_x, w_play_y;
    logic             w_play_dx, w_play_dy;
    logic             w_l_hit, w_r_hit, w_miss_l, w_miss_r;
    logic [3:0]       w_score_src, w_score_new;
    logic             w_pads_live, w_enter_serve, w_enter_idle, w_srv_dir_nxt;

    // Edge-detect the vblank corner so a stalled sync generator still yields one tick per frame.
    assign w_vb = (bus.hsp == 10'd0) && (bus.vsp == 10'd480);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_tick <= 1'b0;
            r_vb_d       <= 1'b0;
        end else begin
            r_frame_tick <= w_vb & ~r_vb_d;
            r_vb_d       <= w_vb;
        end
    end

    function automatic logic [9:0] pad_next(input logic [9:0] y, input logic up, input logic dn);
        logic signed [11:0] t;
        t = $signed({2'b00, y});
        if (up && !dn)
            t = t - C_PSPD;
        else if (dn && !up)
            t = t + C_PSPD;
        if (t < C_ZERO)
            t = C_ZERO;
        else if (t > C_PADMAX)
            t = C_PADMAX;
        return 10'(t);
    endfunction

    assign w_bx = $signed({2'b00, r_ball_x});
    assign w_by = $signed({2'b00, r_ball_y});
    assign w_pl = $signed({2'b00, r_pad_l});
    assign w_pr = $signed({2'b00, r_pad_r});
    assign w_nx = r_dx ? (w_bx + C_BSPD) : (w_bx - C_BSPD);
    assign w_ny = r_dy ? (w_by + C_BSPD) : (w_by - C_BSPD);

    // Paddle overlap uses the ball row before this frame's move.
    assign w_l_hit  = !r_dx && (w_bx >= C_LFACE) && (w_nx <= C_LFACE)
                      && (w_by + C_EIGHT > w_pl) && (w_by < w_pl + C_PADH);
    assign w_r_hit  = r_dx && (w_bx + C_EIGHT <= C_RFACE) && (w_nx + C_EIGHT >= C_RFACE)
                      && (w_by + C_EIGHT > w_pr) && (w_by < w_pr + C_PADH);
    assign w_miss_l = (w_nx <= C_ZERO) && !w_l_hit;
    assign w_miss_r = (w_nx >= C_XMAX) && !w_r_hit;

    always_comb begin
        w_play_y  = w_ny;
        w_play_dy = r_dy;
        if (w_ny < C_ZERO) begin
            w_play_y  = C_ZERO;
            w_play_dy = 1'b1;
        end else if (w_ny > C_YMAX) begin
            w_play_y  = C_YMAX;
            w_play_dy = 1'b0;
        end
        w_play_x  = w_nx;
        w_play_dx = r_dx;
        if (w_l_hit) begin
            w_play_x  = C_LFACE;
            w_play_dx = 1'b1;
        end else if (w_r_hit) begin
            w_play_x  = C_RSTOP;
            w_play_dx = 1'b0;
        end
    end

    assign w_score_src = r_point_r ? r_score_r : r_score_l;
    assign w_score_new = (w_score_src == 4'd15) ? 4'd15 : (w_score_src + 4'd1);

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_frame_tick) begin
            case (r_state)
                S_IDLE:  if (bus.start) w_state_nxt = S_SERVE;
                S_SERVE: if (r_cnt == CNT_LAST) w_state_nxt = S_PLAY;
                S_PLAY:  if (w_miss_l || w_miss_r) w_state_nxt = S_POINT;
                S_POINT: w_state_nxt = (w_score_new == C_WIN) ? S_OVER : S_SERVE;
                S_OVER:  if (bus.start) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_pads_live   = (r_state == S_SERVE) || (r_state == S_PLAY) || (r_state == S_POINT);
        w_enter_serve = r_frame_tick && (w_state_nxt == S_SERVE) && (r_state != S_SERVE);
        w_enter_idle  = r_frame_tick && (w_state_nxt == S_IDLE) && (r_state != S_IDLE);
        w_srv_dir_nxt = (r_state == S_POINT) ? ~r_point_r : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ball_x  <= BALL_X0;
            r_ball_y  <= BALL_Y0;
            r_pad_l   <= PAD_Y0;
            r_pad_r   <= PAD_Y0;
            r_score_l <= 4'd0;
            r_score_r <= 4'd0;
            r_dx      <= 1'b1;
            r_dy      <= 1'b1;
            r_srv_dir <= 1'b1;
            r_point_r <= 1'b0;
            r_cnt     <= '0;
        end else if (r_frame_tick) begin
            if (w_pads_live) begin
                r_pad_l <= pad_next(r_pad_l, bus.btn_lu, bus.btn_ld);
                r_pad_r <= pad_next(r_pad_r, bus.btn_ru, bus.btn_rd);
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_score_l <= 4'd0;
                        r_score_r <= 4'd0;
                        r_srv_dir <= 1'b1;
                    end
                end
                S_SERVE: r_cnt <= r_cnt + 1'b1;
                S_PLAY: begin
                    r_ball_y <= 10'(w_play_y);
                    r_dy     <= w_play_dy;
                    // On a miss the ball freezes at its last on-screen column.
                    if (w_miss_l || w_miss_r) begin
                        r_point_r <= w_miss_l;
                    end else begin
                        r_ball_x <= 10'(w_play_x);
                        r_dx     <= w_play_dx;
                    end
                end
                S_POINT: begin
                    r_srv_dir <= w_srv_dir_nxt;
                    if (r_point_r)
                        r_score_r <= w_score_new;
                    else
                        r_score_l <= w_score_new;
                end
                default: ;
            endcase
            if (w_enter_serve) begin
                r_ball_x <= BALL_X0;
                r_ball_y <= BALL_Y0;
                r_dx     <= w_srv_dir_nxt;
                r_dy     <= 1'b1;
                r_cnt    <= '0;
            end
            if (w_enter_idle) begin
                r_ball_x <= BALL_X0;
                r_ball_y <= BALL_Y0;
            end
        end
    end

    assign bus.ball_x     = r_ball_x;
    assign bus.ball_y     = r_ball_y;
    assign bus.pad_l_y    = r_pad_l;
    assign bus.pad_r_y    = r_pad_r;
    assign bus.score_l    = r_score_l;
    assign bus.score_r    = r_score_r;
    assign bus.state      = r_state;
    assign bus.frame_tick = r_frame_tick;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: plays scripted rallies frame by frame and checks
// hand-computed ball, paddle, score and state values at chosen frames.
module tb_pong_game_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pong_game_ctrl_if bus();

    pong_game_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s failed", tag);
        end
    endtask

    task automatic check_ball(input string tag, input int x, input int y);
        check({tag, "_x"}, int'(bus.ball_x), x);
        check({tag, "_y"}, int'(bus.ball_y), y);
    endtask

    // One frame: present the vblank corner for one cycle, then sample after the update edge.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.hsp = 10'd0;
            bus.vsp = 10'd480;
            @(negedge clk);
            bus.hsp = 10'd17;
            bus.vsp = 10'd100;
            @(negedge clk);
        end
    endtask

    task automatic set_btn(input logic lu, input logic ld, input logic ru, input logic rd);
        bus.btn_lu = lu;
        bus.btn_ld = ld;
        bus.btn_ru = ru;
        bus.btn_rd = rd;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        bus.hsp   = 10'd17;
        bus.vsp   = 10'd100;
        bus.start = 1'b0;
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        check("rst_state", int'(bus.state), 0);
        check_ball("rst_ball", 316, 236);
        check("rst_pad_l", int'(bus.pad_l_y), 208);
        check("rst_pad_r", int'(bus.pad_r_y), 208);
        check("rst_score_l", int'(bus.score_l), 0);
        check("rst_score_r", int'(bus.score_r), 0);
        check("rst_tick", int'(bus.frame_tick), 0);

        rst = 1'b0;
        @(negedge clk);
        check("tick_idle_low", int'(bus.frame_tick), 0);

        // Corner held for several cycles still gives a single pulse.
        bus.hsp = 10'd0;
        bus.vsp = 10'd480;
        @(negedge clk);
        check("tick_pulse", int'(bus.frame_tick), 1);
        @(negedge clk);
        check("tick_one_cycle", int'(bus.frame_tick), 0);
        bus.hsp = 10'd17;
        bus.vsp = 10'd100;
        @(negedge clk);
        check("tick_stays_low", int'(bus.frame_tick), 0);
        check("idle_no_start", int'(bus.state), 0);

        // Game 1, rally 1: serve right, left paddle up, right paddle down.
        bus.start = 1'b1;
        ticks(1);
        bus.start = 1'b0;
        check("start_state", int'(bus.state), 1);
        check_ball("serve_ball", 316, 236);
        set_btn(1'b1, 1'b0, 1'b0, 1'b1);
        ticks(1);
        check("pad_l_first", int'(bus.pad_l_y), 204);
        check("pad_r_first", int'(bus.pad_r_y), 212);
        ticks(51);
        check("pad_l_floor", int'(bus.pad_l_y), 0);
        check("pad_r_ceil", int'(bus.pad_r_y), 416);
        ticks(7);
        check("serve_59", int'(bus.state), 1);
        ticks(1);
        check("serve_60", int'(bus.state), 2);
        check("pad_l_held0", int'(bus.pad_l_y), 0);
        check("pad_r_held416", int'(bus.pad_r_y), 416);

        set_btn(1'b1, 1'b1, 1'b1, 1'b1);
        ticks(1);
        check_ball("play_k1", 318, 238);
        check("both_pad_l", int'(bus.pad_l_y), 0);
        check("both_pad_r", int'(bus.pad_r_y), 416);
        ticks(1);
        check_ball("play_k2", 320, 240);
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);

        ticks(116);
        check_ball("bottom_reach", 552, 472);
        ticks(1);
        check_ball("bottom_clamp", 554, 472);
        ticks(1);
        check_ball("bottom_bounce", 556, 470);
        ticks(26);
        check_ball("r_paddle_hit", 608, 418);
        ticks(1);
        check_ball("after_r_hit", 606, 416);
        ticks(209);
        check_ball("top_bounce", 188, 0);
        ticks(1);
        check_ball("after_top", 186, 2);
        ticks(93);
        check("miss_l_state", int'(bus.state), 3);
        check_ball("miss_l_ball", 2, 188);
        check("miss_l_score", int'(bus.score_r), 0);
        ticks(1);
        check("point_r_state", int'(bus.state), 1);
        check("point_r_score_r", int'(bus.score_r), 1);
        check("point_r_score_l", int'(bus.score_l), 0);
        check_ball("reserve_ball", 316, 236);

        // Rally 2: serve toward left; left paddle drops to meet the ball.
        set_btn(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(60);
        check("r2_play", int'(bus.state), 2);
        check("r2_pad_l", int'(bus.pad_l_y), 240);
        ticks(50);
        check("r2_pad_l_max", int'(bus.pad_l_y), 416);
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);
        ticks(95);
        check_ball("r2_pre_hit", 26, 420);
        ticks(1);
        check_ball("l_paddle_hit", 24, 418);
        ticks(1);
        check_ball("after_l_hit", 26, 416);
        ticks(303);
        check("miss_r_state", int'(bus.state), 3);
        check_ball("miss_r_ball", 630, 188);
        ticks(1);
        check("point_l_state", int'(bus.state), 1);
        check("point_l_score_l", int'(bus.score_l), 1);
        check("point_l_score_r", int'(bus.score_r), 1);

        // Rally 3: serve right, right paddle moved out of the ball path; start ignored in SERVE.
        set_btn(1'b0, 1'b0, 1'b1, 1'b0);
        bus.start = 1'b1;
        ticks(1);
        bus.start = 1'b0;
        check("start_ignored", int'(bus.state), 1);
        ticks(59);
        check("r3_play", int'(bus.state), 2);
        check("r3_pad_r", int'(bus.pad_r_y), 176);
        set_btn(1'b0, 1'b0, 1'b0, 1'b0);
        ticks(158);
        check("r3_miss", int'(bus.state), 3);
        check_ball("r3_miss_ball", 630, 394);
        ticks(1);
        check("r3_score_l", int'(bus.score_l), 2);

        for (int s = 3; s <= 7; s++) begin
            ticks(219);
            check("rally_score_l", int'(bus.score_l), s);
            check("rally_state", int'(bus.state), (s == 7) ? 4 : 1);
        end
        check("over_score_r", int'(bus.score_r), 1);
        ticks(3);
        check("over_hold_state", int'(bus.state), 4);
        check("over_hold_score", int'(bus.score_l), 7);
        check_ball("over_hold_ball", 630, 394);
        check("over_hold_pad_r", int'(bus.pad_r_y), 176);

        bus.start = 1'b1;
        ticks(1);
        bus.start = 1'b0;
        check("over_to_idle", int'(bus.state), 0);
        check_ball("idle_ball", 316, 236);

        // Game 2: fresh scores, one left point, then reset mid-PLAY.
        bus.start = 1'b1;
        ticks(1);
        bus.start = 1'b0;
        check("g2_state", int'(bus.state), 1);
        check("g2_score_l", int'(bus.score_l), 0);
        check("g2_score_r", int'(bus.score_r), 0);
        ticks(219);
        check("g2_point", int'(bus.score_l), 1);
        check("g2_serve", int'(bus.state), 1);

        // Button activity between frames must not move a paddle.
        bus.btn_rd = 1'b1;
        repeat (4) @(negedge clk);
        bus.btn_rd = 1'b0;
        bus.btn_lu = 1'b1;
        ticks(1);
        check("between_tick_pad_r", int'(bus.pad_r_y), 176);
        check("g2_pad_l", int'(bus.pad_l_y), 412);
        ticks(62);
        check("g2_midplay", int'(bus.state), 2);
        check("g2_pad_l_mid", int'(bus.pad_l_y), 164);

        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_state", int'(bus.state), 0);
        check("mid_rst_score_l", int'(bus.score_l), 0);
        check("mid_rst_score_r", int'(bus.score_r), 0);
        check_ball("mid_rst_ball", 316, 236);
        check("mid_rst_pad_l", int'(bus.pad_l_y), 208);
        check("mid_rst_pad_r", int'(bus.pad_r_y), 208);
        rst = 1'b0;
        bus.btn_lu = 1'b0;

        bus.start = 1'b1;
        ticks(1);
        bus.start = 1'b0;
        check("post_rst_start", int'(bus.state), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameters (name, default, meaning): BALL_SPD=2, ball pixels/frame per axis; PAD_SPD=4, paddle pixels/frame; PAD_H=64, paddle height; SERVE_FRAMES=60, serve delay in frames; WIN_SCORE=7, winning score.
REQ-002 Clock and reset SHALL be a single clock and a synchronous, active-high reset:
  clk  in  1  pixel clock, shared with the sync generator.
  rst  in  1  synchronous, active-high reset.
REQ-003 Inputs SHALL be:
  hsp  in  10  horizontal position, 0..800.
  vsp  in  10  vertical position, 0..525.
  btn_lu, btn_ld, btn_ru, btn_rd  in  1 each  paddle up/down, synchronised, level.
  start  in  1  start request, level.
REQ-004 Outputs SHALL be:
  ball_x, ball_y  out  10  ball top-left corner, 8x8 ball.
  pad_l_y, pad_r_y  out  10  paddle top edge.
  score_l, score_r  out  4  player scores.
  state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
  frame_tick  out  1  one-cycle pulse per frame.

Function
REQ-005 frame_tick SHALL be registered high for exactly one cycle, in the cycle after hsp==0 and vsp==480 (start of vblank), once per frame.
REQ-006 All position, score and state updates SHALL occur only in the cycle frame_tick is high, so outputs are stable throughout the display area.
REQ-007 Paddles, in all states except IDLE and OVER:
  - up only: y -= PAD_SPD; down only: y += PAD_SPD; both or neither: hold.
  - Result SHALL clamp to 0..480-PAD_H (416).
REQ-008 Arithmetic SHALL use at least 11-bit signed intermediates; no 10-bit wrap may reach any output.
REQ-009 IDLE: ball at (316,236). start high at a tick -> clear both scores, serve direction = right, go to SERVE.
REQ-010 SERVE: on entry, ball = (316,236), dy = down, and the frame counter clears. After SERVE_FRAMES ticks -> PLAY.
REQ-011 PLAY, at each tick: nx = ball_x ± BALL_SPD and ny = ball_y ± BALL_SPD per dx/dy, then apply REQ-012..REQ-015.
REQ-012 Wall bounce:
  - ny < 0 -> ball_y = 0, dy = down.
  - ny > 472 -> ball_y = 472, dy = up.
REQ-013 Left paddle (face x=24):
  - Condition: dx = left, ball_x >= 24, nx <= 24, and ball_y+8 > pad_l_y and ball_y < pad_l_y+PAD_H.
  - Response: ball_x = 24, dx = right.
  - Right paddle mirrors this at face x=616: ball_x+8 <= 616, nx+8 >= 616 -> ball_x = 608, dx = left.
REQ-014 Miss:
  - nx <= 0 with no left hit -> point to right player.
  - nx >= 632 with no right hit -> point to left player.
  - Either -> POINT; ball_x holds its last in-range value.
REQ-015 When wall and paddle events coincide in one tick, both SHALL apply (corner bounce flips dx and dy).
REQ-016 POINT, for one tick:
  - Increment the scorer's score, saturating at 15.
  - Serve direction = toward the player who conceded.
  - New score == WIN_SCORE -> OVER; otherwise -> SERVE.
REQ-017 OVER: hold scores and positions. start high at a tick -> IDLE. start is ignored in all other states except IDLE.
REQ-018 Buttons and start SHALL be sampled only at frame_tick; changes between ticks have no effect.

Reset
REQ-019 While rst is high at a clock edge, the block SHALL load on that edge, overriding any in-progress operation:
  - state = IDLE.
  - ball = (316,236).
  - pad_l_y = pad_r_y = 208.
  - scores = 0, frame_tick = 0, serve direction = right, dx = right, dy = down, frame counter = 0.
REQ-020 After rst is released, the first frame_tick SHALL occur at the next hsp==0/vsp==480 crossing.

Verification
REQ-021 Reset mid-PLAY (score 3-2) -> next cycle: state=0, scores 0/0, ball (316,236), paddles 208.
REQ-022 start at IDLE tick -> state=1; after 60 ticks -> state=2, ball advances (+2,+2) per tick.
REQ-023 btn_lu held 60 frames from pad_l_y=208 -> 204,200,...,0, then stays 0; btn_lu and btn_ld together -> no change.
REQ-024 Ball at y=472 moving down -> y stays 472, dy=up; next tick y=470. Ball at x=24 moving left with paddle overlapping -> dx=right.
REQ-025 Left paddle at 0, ball_y=300 moving left -> miss; score_r increments; serve goes toward left; state 3 -> 1.
REQ-026 score_l=6, left scores -> score_l=7, state=4, further ticks do not change; start -> state=0.
